ushift_seq_ctrl: RTL and testbench
==================================

Name: ushift_seq_ctrl

Overview:
- Command-driven sequencer wrapping a WIDTH-bit universal shift register: load, hold, shift right/left by 1 per cycle.
- Accepts one command at a time over a valid/ready handshake: load, multi-bit shift, or multi-bit rotate.
- Drives the register's 2-bit mode select and serial fill bits, counts shift cycles, and pulses done on completion.
- Sits between a host/bus-side command source and the shift datapath; the datapath is reused unchanged as a sub-module.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the shift-amount field and the internal down-counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  3  opcode (see Behaviour).
- cmd_amt  input  CNT_W  shift/rotate amount.
- cmd_data  input  WIDTH  parallel load value.
- ser_in  input  1  external fill bit for opcode SHRS.
- data_out  output  WIDTH  current register contents, continuous.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse with done for an unsupported opcode.

Behaviour:
- Reset (rst=0, asynchronous):
  - Register clears to 0; FSM goes to IDLE; counter clears to 0.
  - Outputs: cmd_ready=1, busy=0, done=0, err=0, data_out=0.
  - Reset mid-command aborts with no done pulse.
- Mode select to the datapath (these encodings are fixed):
  - 00 hold.
  - 01 shift right: fill bit enters the MSB.
  - 10 shift left: fill bit enters the LSB.
  - 11 parallel load.
  - In IDLE and DONE the select is 00.
- Handshake:
  - A command is accepted on the cycle where cmd_valid & cmd_ready. Op, amt and data are captured that cycle.
  - cmd_ready=0 from the next cycle until the cycle after done.
- Opcodes:
  - 000 NOP.
  - 001 LOAD (cmd_data).
  - 010 SHR, zero fill.
  - 011 SHL, zero fill.
  - 100 ROR: fill = current LSB.
  - 101 ROL: fill = current MSB.
  - 110 ASR: fill = current MSB. Optional, see below.
  - 111 SHRS: fill = ser_in, sampled on each shift cycle.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE -> LOAD on accepted LOAD.
  - IDLE -> SHIFT on an accepted shift/rotate with amt != 0.
  - IDLE -> DONE on NOP, amt == 0, or an unsupported opcode.
  - LOAD: one cycle with select 11, then DONE.
  - SHIFT: one bit per cycle, counter decrements; when counter == 1 the shift completes and the FSM goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency from the accept cycle to the done cycle:
  - LOAD: 2 cycles.
  - Shift by n (n >= 1): n+1 cycles.
  - NOP / amt == 0: 1 cycle.
- Amount saturation: cmd_amt > WIDTH saturates to WIDTH. SHR/SHL by WIDTH clears the register; rotate by WIDTH returns the original value.
- busy = (state != IDLE).
- data_out reflects each intermediate shift. Its value is stable in DONE.
- cmd_valid while busy is ignored, not queued. The source must hold it until cmd_ready.

Optional Feature:
- Macro: USHIFT_ASR_EN.
- Defined: opcode 110 performs an arithmetic shift right by amt; the MSB is replicated.
- Undefined: opcode 110 is unsupported. It goes IDLE -> DONE, the register is unchanged, and err=1 coincides with done.
- err is otherwise always 0.

Decomposition:
- Shared package ushift_pkg holds:
  - opcode localparams OP_NOP..OP_SHRS;
  - mode-select constants SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11;
  - FSM state enum.
- One sub-module is natural: ushift_core.
  - Contents: a parameterised WIDTH-bit universal shift register of per-bit D flip-flops with async active-low clear, each fed by a 4:1 mux.
  - Interface: sel, msb_in, lsb_in, par_in, q.
  - The controller holds only the FSM, the counter and the fill-bit muxing.

Test Plan (all with WIDTH=4):
- Reset mid-SHL, then recovery: accept SHL amt=3, assert rst after 1 shift -> data_out=0000, state IDLE, cmd_ready=1, no done; then issue LOAD 1010 -> done 2 cycles after accept.
- LOAD 1101 then ROR amt=1 -> data_out=1110, done 2 cycles after accept; ROL amt=4 from 1110 -> 1110.
- LOAD 1001, SHL amt=2 -> 0100; then SHR amt=7 (saturates to 4) -> 0000, done 5 cycles after accept.
- SHRS amt=3 with ser_in sequence 1,0,1 on successive shift cycles, starting from 0000 -> 1010.
- cmd_valid held high during a SHR amt=2 -> second command accepted only after done; NOP/amt=0 -> done the cycle after accept, register unchanged.
- ASR opcode on 1000, amt=2: with USHIFT_ASR_EN -> 1110, err=0; without -> register unchanged at 1000, done and err pulse together.

Source files
------------

// File: rtl/ushift_pkg.sv
// Shared opcodes, datapath mode-select encodings and controller state type
// for the command-driven universal shift register.
package ushift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_SHRS = 3'b111;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ushift_core.sv
// WIDTH-bit universal shift register: per-bit flop with async active-low
// clear, fed by a 4:1 mux (hold / shift right / shift left / parallel load).
module ushift_core
  import ushift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q
);

  // Neighbour vectors padded with the fill bits so every bit uses the same mux.
  logic [WIDTH:0] right_src;
  logic [WIDTH:0] left_src;

  assign right_src = {msb_in, q};
  assign left_src  = {q, lsb_in};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic d_next;

      always_comb begin
        d_next = q[gi];
        case (sel)
          SEL_SHR:  d_next = right_src[gi+1];
          SEL_SHL:  d_next = left_src[gi];
          SEL_LOAD: d_next = par_in[gi];
          default:  d_next = q[gi];
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q[gi] <= 1'b0;
        else      q[gi] <= d_next;
      end
    end
  endgenerate

endmodule

// File: rtl/ushift_seq_ctrl.sv
// Command sequencer around ushift_core: load, multi-bit shift and rotate.
// Define USHIFT_ASR_EN to support opcode 110 (arithmetic shift right).
module ushift_seq_ctrl
  import ushift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef USHIFT_ASR_EN
  localparam bit ASR_EN = 1'b1;
`else
  localparam bit ASR_EN = 1'b0;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] load_reg, load_next;
  logic             err_reg, err_next;

  logic [1:0]       sel;
  logic             msb_fill;
  logic             lsb_fill;
  logic             accept;
  logic             op_shift;
  logic             op_unsup;
  logic [CNT_W-1:0] amt_sat;

  assign accept  = cmd_valid & cmd_ready;
  assign amt_sat = (cmd_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_amt;
  assign op_unsup = (cmd_op == OP_ASR) && !ASR_EN;

  always_comb begin
    op_shift = 1'b0;
    case (cmd_op)
      OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_SHRS: op_shift = 1'b1;
      OP_ASR:                                  op_shift = ASR_EN;
      default:                                 op_shift = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_NOP;
      load_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      load_reg  <= load_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    load_next  = load_reg;
    err_next   = err_reg;
    sel        = SEL_HOLD;
    msb_fill   = 1'b0;
    lsb_fill   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next   = cmd_op;
          load_next = cmd_data;
          cnt_next  = amt_sat;
          err_next  = op_unsup;
          if (cmd_op == OP_LOAD)                     state_next = ST_LOAD;
          else if (op_shift && (amt_sat != '0))      state_next = ST_SHIFT;
          else                                       state_next = ST_DONE;
        end
      end
      ST_LOAD: begin
        sel        = SEL_LOAD;
        state_next = ST_DONE;
      end
      ST_SHIFT: begin
        // Fill bits come from the live register so rotates see each intermediate value.
        case (op_reg)
          OP_SHL:  sel = SEL_SHL;
          OP_ROL:  begin sel = SEL_SHL; lsb_fill = data_out[WIDTH-1]; end
          OP_ROR:  begin sel = SEL_SHR; msb_fill = data_out[0];       end
          OP_ASR:  begin sel = SEL_SHR; msb_fill = data_out[WIDTH-1]; end
          OP_SHRS: begin sel = SEL_SHR; msb_fill = ser_in;            end
          default: sel = SEL_SHR;
        endcase
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        err_next   = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err       = done & err_reg;

  ushift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .msb_in (msb_fill),
    .lsb_in (lsb_fill),
    .par_in (load_reg),
    .q      (data_out)
  );

endmodule

// File: tb/tb_ushift_seq_ctrl.sv
// Directed bench for ushift_seq_ctrl (WIDTH=4); honours USHIFT_ASR_EN.
module tb_ushift_seq_ctrl;
  import ushift_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [CNT_W-1:0] cmd_amt = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             ser_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic             err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ushift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Issue one command from an idle negedge; returns accept-to-done latency
  // and err at the done cycle, and leaves the bench at the next idle negedge.
  task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] amt,
                      input logic [WIDTH-1:0] data, input logic [3:0] ser_seq,
                      output int lat, output logic err_seen);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    ser_in = ser_seq[0];
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat - 1 < 4) ser_in = ser_seq[lat-1];
    end
    err_seen = err;
    $display("cmd op=%b amt=%0d data=%b -> data_out=%b lat=%0d err=%b", op, amt, data, data_out, lat, err_seen);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    n_vec++; if (data_out !== 4'b0000) begin n_bad++; $display("FAIL reset_data got %b want 0000", data_out); end
    n_vec++; if ({cmd_ready, busy, done, err} !== 4'b1000) begin n_bad++; $display("FAIL reset_flags got %b want 1000", {cmd_ready, busy, done, err}); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({cmd_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL idle_after_reset got %b want 10", {cmd_ready, busy}); end
  endtask

  task automatic test_reset_mid_shl;
    int lat; logic e;
    send(OP_LOAD, 3'd0, 4'b0011, 4'b0000, lat, e);
    cmd_valid = 1'b1; cmd_op = OP_SHL; cmd_amt = 3'd3;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (data_out !== 4'b0110) begin n_bad++; $display("FAIL shl_first_step got %b want 0110", data_out); end
    rst = 1'b0;
    #1;
    n_vec++; if (data_out !== 4'b0000) begin n_bad++; $display("FAIL abort_data got %b want 0000", data_out); end
    n_vec++; if ({cmd_ready, busy, done} !== 3'b100) begin n_bad++; $display("FAIL abort_flags got %b want 100", {cmd_ready, busy, done}); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got %b want 0", done); end
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-SHL -> data_out=%b", data_out);
    send(OP_LOAD, 3'd0, 4'b1010, 4'b0000, lat, e);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL recover_load_lat got %0d want 2", lat); end
    n_vec++; if (data_out !== 4'b1010) begin n_bad++; $display("FAIL recover_load_data got %b want 1010", data_out); end
  endtask

  task automatic test_rotate;
    int lat; logic e;
    send(OP_LOAD, 3'd0, 4'b1101, 4'b0000, lat, e);
    send(OP_ROR, 3'd1, 4'b0000, 4'b0000, lat, e);
    n_vec++; if (data_out !== 4'b1110) begin n_bad++; $display("FAIL ror1_data got %b want 1110", data_out); end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL ror1_lat got %0d want 2", lat); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL ror1_err got %b want 0", e); end
    send(OP_ROL, 3'd4, 4'b0000, 4'b0000, lat, e);
    n_vec++; if (data_out !== 4'b1110) begin n_bad++; $display("FAIL rol4_data got %b want 1110", data_out); end
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL rol4_lat got %0d want 5", lat); end
    send(OP_ROL, 3'd1, 4'b0000, 4'b0000, lat, e);
    n_vec++; if (data_out !== 4'b1101) begin n_bad++; $display("FAIL rol1_data got %b want 1101", data_out); end
  endtask

  task automatic test_shift_saturate;
    int lat; logic e;
    send(OP_LOAD, 3'd0, 4'b1001, 4'b0000, lat, e);
    send(OP_SHL, 3'd2, 4'b0000, 4'b0000, lat, e);
    n_vec++; if (data_out !== 4'b0100) begin n_bad++; $display("FAIL shl2_data got %b want 0100", data_out); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL shl2_lat got %0d want 3", lat); end
    send(OP_SHR, 3'd7, 4'b0000, 4'b0000, lat, e);
    n_vec++; if (data_out !== 4'b0000) begin n_bad++; $display("FAIL shr7_data got %b want 0000", data_out); end
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL shr7_lat got %0d want 5", lat); end
  endtask

  task automatic test_shrs;
    int lat; logic e;
    send(OP_LOAD, 3'd0, 4'b0000, 4'b0000, lat, e);
    send(OP_SHRS, 3'd3, 4'b0000, 4'b0101, lat, e);
    n_vec++; if (data_out !== 4'b1010) begin n_bad++; $display("FAIL shrs_data got %b want 1010", data_out); end
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL shrs_lat got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic e;
    send(OP_LOAD, 3'd0, 4'b0110, 4'b0000, lat, e);
    cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_amt = 3'd2;
    @(posedge clk); @(negedge clk);
    cmd_op = OP_LOAD; cmd_data = 4'b1111;
    n_vec++; if ({busy, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL held_busy got %b want 10", {busy, cmd_ready}); end
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL held_shr_lat got %0d want 3", lat); end
    n_vec++; if (data_out !== 4'b0001) begin n_bad++; $display("FAIL held_shr_data got %b want 0001", data_out); end
    $display("held SHR amt=2 -> data_out=%b lat=%0d", data_out, lat);
    @(negedge clk);
    n_vec++; if ({cmd_ready, data_out} !== 5'b10001) begin n_bad++; $display("FAIL held_idle got %b want 10001", {cmd_ready, data_out}); end
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL held_load_lat got %0d want 2", lat); end
    n_vec++; if (data_out !== 4'b1111) begin n_bad++; $display("FAIL held_load_data got %b want 1111", data_out); end
    $display("held LOAD 1111 -> data_out=%b lat=%0d", data_out, lat);
    @(negedge clk);
    send(OP_NOP, 3'd3, 4'b0000, 4'b0000, lat, e);
    n_vec++; if ({lat == 1, data_out} !== 5'b11111) begin n_bad++; $display("FAIL nop got lat=%0d data=%b want lat=1 data=1111", lat, data_out); end
    send(OP_SHR, 3'd0, 4'b0000, 4'b0000, lat, e);
    n_vec++; if ({lat == 1, data_out} !== 5'b11111) begin n_bad++; $display("FAIL amt0 got lat=%0d data=%b want lat=1 data=1111", lat, data_out); end
  endtask

  task automatic test_asr;
    int lat; logic e;
    send(OP_LOAD, 3'd0, 4'b1000, 4'b0000, lat, e);
    send(OP_ASR, 3'd2, 4'b0000, 4'b0000, lat, e);
`ifdef USHIFT_ASR_EN
    n_vec++; if (data_out !== 4'b1110) begin n_bad++; $display("FAIL asr_data got %b want 1110", data_out); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL asr_lat got %0d want 3", lat); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL asr_err got %b want 0", e); end
`else
    n_vec++; if (data_out !== 4'b1000) begin n_bad++; $display("FAIL asr_data got %b want 1000", data_out); end
    n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL asr_lat got %0d want 1", lat); end
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL asr_err got %b want 1", e); end
`endif
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_after_done got %b want 0", err); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_shl;
    test_rotate;
    test_shift_saturate;
    test_shrs;
    test_back_to_back;
    test_asr;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
